// File: rtl/piso_y_pkg.sv
// Shared sizing for the piso_y parallel-to-serial converter.
// DATA_WIDTH and PE_NUM are defined only here; every other file imports them.
package piso_y_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int PE_NUM     = 32;
   localparam int WORD_W     = 2 * DATA_WIDTH;
   localparam int FRAME_W    = PE_NUM * WORD_W;
   localparam int CNT_W      = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PE_NUM - 1);
endpackage

// File: rtl/piso_y.sv
// Parallel frame in, one complex word per cycle out. A hold register decouples the
// producer from the shifter so the next frame can start with no bubble.
module piso_y
   import piso_y_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               p_in_v,
   input  logic [FRAME_W-1:0] p_in,
   output logic               p_in_rdy,
   input  logic               s_out_rdy,
   output logic               s_out_v,
   output logic [WORD_W-1:0]  s_out,
   output logic               s_out_last
);

   logic [FRAME_W-1:0] r_hold;
   logic               r_hold_full;
   logic [FRAME_W-1:0] r_shift;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;

   logic w_accept, w_consume, w_last, w_xfer;

   assign w_last    = (r_cnt == LAST_LANE);
   assign w_consume = r_busy && s_out_rdy;
   assign w_accept  = p_in_v && p_in_rdy;
   // Refill the shifter when idle, or on the very edge its last lane leaves.
   assign w_xfer    = r_hold_full && (!r_busy || (w_consume && w_last));

   assign p_in_rdy   = !r_hold_full && !rst;
   assign s_out_v    = r_busy;
   assign s_out      = r_busy ? r_shift[WORD_W-1:0] : '0;
   assign s_out_last = r_busy && w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
      end else begin
         // accept and transfer are exclusive: accept needs the hold empty
         if (w_accept) begin
            r_hold      <= p_in;
            r_hold_full <= 1'b1;
         end
         if (w_xfer) begin
            r_shift     <= r_hold;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_hold_full <= 1'b0;
         end else if (w_consume) begin
            r_shift <= r_shift >> WORD_W;
            if (w_last) begin
               r_cnt  <= '0;
               r_busy <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/piso_y.md
PISO_Y -- requirements
Module: piso_y

Interface
REQ-001 Parameters SHALL come from parameters.vh: DATA_WIDTH (default 16), one real/imag component width; PE_NUM (default 32), number of PE lanes per frame.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 p_in_v  input  1  parallel frame valid.
REQ-005 p_in  input  PE_NUM*DATA_WIDTH*2  frame; lane i = bits [i*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-006 p_in_rdy  output  1  high = hold buffer can accept a frame.
REQ-007 s_out_rdy  input  1  downstream ready for serial data.
REQ-008 s_out_v  output  1  serial word valid.
REQ-009 s_out  output  DATA_WIDTH*2  serial word.
REQ-010 s_out_last  output  1  marks lane PE_NUM-1 of a frame.

Function
REQ-011 Two-stage buffering SHALL be used: a hold register (frame + full flag) feeding a shift register (frame + lane counter + busy flag).
REQ-012 Accept: p_in_v && p_in_rdy at edge t SHALL capture p_in into the hold register.
REQ-013 p_in_rdy SHALL equal !hold_full && !rst, with no combinational path from p_in_v or s_out_rdy.
REQ-014 Transfer: hold full with shifter idle, or hold full with the last lane consumed at this edge, SHALL move hold to shifter at that edge, set lane counter to 0 and clear hold_full.
REQ-015 Latency: a frame accepted at edge t with the pipeline empty SHALL present lane 0 with s_out_v=1 after edge t+1.
REQ-016 Order: lane 0 first, lane PE_NUM-1 last. This is the inverse of the sipo_y lane mapping.
REQ-017 A serial word SHALL be consumed only when s_out_v && s_out_rdy; each consumption increments the lane counter by 1.
REQ-018 s_out_rdy=0 SHALL freeze s_out, s_out_v, s_out_last and the lane counter.
REQ-019 Consuming lane PE_NUM-1 SHALL wrap the counter to 0. With hold empty, busy clears and s_out_v=0 on the next cycle. With hold full, the next frame starts with no bubble cycle.
REQ-020 s_out_last SHALL be high exactly when s_out_v=1 and counter == PE_NUM-1.
REQ-021 An accept into the hold register at the same edge as a hold-to-shifter transfer cannot occur, because p_in_rdy was 0. p_in_v with p_in_rdy=0 SHALL be ignored, and the source holds p_in.
REQ-022 When s_out_v=0, s_out SHALL be driven to 0.
REQ-023 The counter width SHALL be clog2(PE_NUM); PE_NUM need not be a power of 2.

Reset
REQ-024 rst=1 at an edge SHALL clear hold_full, busy, the lane counter and both frame registers, giving s_out=0, s_out_v=0, s_out_last=0.
REQ-025 Reset mid-frame SHALL discard remaining lanes and any held frame; the first frame after reset SHALL start at lane 0.
REQ-026 p_in_rdy SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.

Structure
REQ-027 DATA_WIDTH and PE_NUM SHALL be used only via the shared parameters.vh header; no local redefinition.
REQ-028 No sub-module is required; the hold register, shifter and counter are inline.
REQ-029 Frame state SHALL be controlled by two flags, hold_full and busy; no separate FSM encoding.

Verification
REQ-030 Single frame: PE_NUM=32, lanes = 1..32, s_out_rdy=1. Required: s_out = 1,2,...,32 on 32 consecutive cycles from edge t+1; s_out_last only on 32; then s_out_v=0.
REQ-031 Back-to-back: two frames 1..32 and 33..64 offered consecutively. Required: 64 consecutive valid words 1..64 with no gap; s_out_last on 32 and 64; p_in_rdy low while the hold register is full.
REQ-032 Backpressure: drop s_out_rdy for 3 cycles while s_out=5. Required: s_out stays 5 with s_out_v=1; the sequence resumes 6,7,... with nothing lost or duplicated.
REQ-033 Overflow: offer three frames back-to-back. Required: the third p_in_v waits with p_in_rdy=0 until the first frame's lane 31 is consumed; all 96 words emerge in order.
REQ-034 Reset mid-shift: rst=1 for one cycle after lane 10 is output, with hold full. Required: next cycle s_out_v=0 and s_out=0, p_in_rdy=1 after rst falls; a new frame 101..132 emits from 101.
REQ-035 The bench SHALL check, on every cycle, that lanes are never skipped or duplicated and that s_out_last appears exactly once per frame.
